effect_param_ctrl: RTL and testbench

- Key-driven controller holding NUM_PARAMS effect parameters (e.g. echo delay time, echo volume).
- Features:
  - debounces two active-low push-buttons;
  - selects the target parameter from slide switches;
  - steps the selected value up or down with per-parameter min/max/step saturation and auto-repeat while held;
  - publishes all values plus a one-cycle update strobe to the effect datapath.
- Sits between the board keys/switches and the audio effect cores.

---
 rtl/effect_param_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_effect_param_ctrl.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/effect_param_ctrl.sv
// Key-driven effect parameter controller: debounced up/down keys step the selected value
// with per-parameter saturation and auto-repeat, and publish every value plus a change strobe.
module effect_param_ctrl #(
    parameter int unsigned NUM_PARAMS = 2,
    parameter int unsigned VAL_W = 8,
    parameter logic [NUM_PARAMS*VAL_W-1:0] PARAM_MIN  = {8'd1, 8'd4},
    parameter logic [NUM_PARAMS*VAL_W-1:0] PARAM_MAX  = {8'd6, 8'd128},
    parameter logic [NUM_PARAMS*VAL_W-1:0] PARAM_STEP = {8'd1, 8'd4},
    parameter logic [NUM_PARAMS*VAL_W-1:0] PARAM_INIT = {8'd1, 8'd64},
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000,
    localparam int unsigned IDX_W = (NUM_PARAMS > 1) ? $clog2(NUM_PARAMS) : 1
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        key_up_n,
    input  logic                        key_down_n,
    input  logic [NUM_PARAMS-1:0]       sel,
    input  logic                        enable_sw,
    output logic                        disabled,
    output logic [NUM_PARAMS*VAL_W-1:0] values,
    output logic                        upd_valid,
    output logic [IDX_W-1:0]            upd_idx
);

    localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W = $clog2(RPT_MAX + 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HOLD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    // Key vectors: bit 0 = up key, bit 1 = down key; raw levels are active-low.
    logic [1:0]            key_meta_q, key_sync_q;
    logic                  en_meta_q, en_sync_q;
    logic [1:0]            key_deb_q, key_deb_d;
    logic [1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [1:0][1:0]       state_q, state_d;
    logic [1:0][RPT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [1:0]            step;
    logic [1:0]            pressed;
    logic                  block_q, block_d, blocked;

    logic [IDX_W-1:0]      sel_idx;
    logic                  sel_any;
    logic [IDX_W:0]        sel_key_q;
    logic                  sel_chg;

    logic [NUM_PARAMS*VAL_W-1:0] values_q, values_d;
    logic                        upd_valid_q, upd_valid_d;
    logic [IDX_W-1:0]            upd_idx_q, upd_idx_d;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            key_meta_q <= 2'b11;
            key_sync_q <= 2'b11;
            en_meta_q  <= 1'b0;
            en_sync_q  <= 1'b0;
            disabled   <= 1'b1;
        end else begin
            key_meta_q <= {key_down_n, key_up_n};
            key_sync_q <= key_meta_q;
            en_meta_q  <= enable_sw;
            en_sync_q  <= en_meta_q;
            disabled   <= ~en_sync_q;
        end
    end

    // Counter tracks consecutive samples disagreeing with the accepted level.
    always_comb begin
        key_deb_d = key_deb_q;
        db_cnt_d  = '0;
        for (int k = 0; k < 2; k++) begin
            if (key_sync_q[k] != key_deb_q[k]) begin
                if (db_cnt_q[k] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    key_deb_d[k] = key_sync_q[k];
                end else begin
                    db_cnt_d[k] = db_cnt_q[k] + 1'b1;
                end
            end
        end
    end

    assign pressed = ~key_deb_q;

    always_comb begin
        sel_idx = '0;
        for (int i = int'(NUM_PARAMS) - 1; i >= 0; i--) begin
            if (sel[i]) sel_idx = IDX_W'(i);
        end
    end

    assign sel_any = |sel;
    assign sel_chg = {sel_any, sel_idx} != sel_key_q;

    // Once both keys are down, neither may step until both have been released.
    always_comb begin
        block_d = block_q;
        if (&pressed) begin
            block_d = 1'b1;
        end else if (~|pressed) begin
            block_d = 1'b0;
        end
    end

    assign blocked = block_q | (&pressed);

    always_comb begin
        state_d   = state_q;
        rpt_cnt_d = rpt_cnt_q;
        step      = '0;
        for (int k = 0; k < 2; k++) begin
            if (!pressed[k] || blocked) begin
                state_d[k]   = ST_IDLE;
                rpt_cnt_d[k] = '0;
            end else begin
                case (state_q[k])
                    ST_IDLE: begin
                        state_d[k]   = ST_HOLD;
                        rpt_cnt_d[k] = '0;
                        step[k]      = 1'b1;
                    end
                    ST_HOLD: begin
                        if (sel_chg) begin
                            rpt_cnt_d[k] = '0;
                        end else if (rpt_cnt_q[k] == RPT_W'(REPEAT_DELAY - 1)) begin
                            state_d[k]   = ST_REPEAT;
                            rpt_cnt_d[k] = '0;
                            step[k]      = 1'b1;
                        end else begin
                            rpt_cnt_d[k] = rpt_cnt_q[k] + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (sel_chg) begin
                            state_d[k]   = ST_HOLD;
                            rpt_cnt_d[k] = '0;
                        end else if (rpt_cnt_q[k] == RPT_W'(REPEAT_PERIOD - 1)) begin
                            rpt_cnt_d[k] = '0;
                            step[k]      = 1'b1;
                        end else begin
                            rpt_cnt_d[k] = rpt_cnt_q[k] + 1'b1;
                        end
                    end
                    default: begin
                        state_d[k]   = ST_IDLE;
                        rpt_cnt_d[k] = '0;
                    end
                endcase
            end
        end
    end

    logic [VAL_W-1:0] cur, mn, mx, st, up_val, dn_val, new_val;
    logic [VAL_W:0]   cur_x, mn_x, mx_x, st_x;
    logic             step_up, step_down;
    int unsigned      base;

    assign base  = VAL_W * int'(sel_idx);
    assign cur   = values_q[base +: VAL_W];
    assign mn    = PARAM_MIN[base +: VAL_W];
    assign mx    = PARAM_MAX[base +: VAL_W];
    assign st    = PARAM_STEP[base +: VAL_W];
    assign cur_x = {1'b0, cur};
    assign mn_x  = {1'b0, mn};
    assign mx_x  = {1'b0, mx};
    assign st_x  = {1'b0, st};

    // Extra bit keeps MIN+STEP from wrapping near the top of the range.
    assign up_val  = (cur_x > mx_x - st_x) ? mx : cur + st;
    assign dn_val  = (cur_x < mn_x + st_x) ? mn : cur - st;
    assign step_up   = step[0] & sel_any;
    assign step_down = step[1] & sel_any;
    assign new_val = step_up ? up_val : dn_val;

    always_comb begin
        values_d    = values_q;
        upd_valid_d = 1'b0;
        upd_idx_d   = upd_idx_q;
        if ((step_up || step_down) && (new_val != cur)) begin
            values_d[base +: VAL_W] = new_val;
            upd_valid_d = 1'b1;
            upd_idx_d   = sel_idx;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            key_deb_q   <= 2'b11;
            db_cnt_q    <= '0;
            state_q     <= {ST_IDLE, ST_IDLE};
            rpt_cnt_q   <= '0;
            block_q     <= 1'b0;
            sel_key_q   <= '0;
            values_q    <= PARAM_INIT;
            upd_valid_q <= 1'b0;
            upd_idx_q   <= '0;
        end else begin
            key_deb_q   <= key_deb_d;
            db_cnt_q    <= db_cnt_d;
            state_q     <= state_d;
            rpt_cnt_q   <= rpt_cnt_d;
            block_q     <= block_d;
            sel_key_q   <= {sel_any, sel_idx};
            values_q    <= values_d;
            upd_valid_q <= upd_valid_d;
            upd_idx_q   <= upd_idx_d;
        end
    end

    assign values    = values_q;
    assign upd_valid = upd_valid_q;
    assign upd_idx   = upd_idx_q;

endmodule

// File: tb/tb_effect_param_ctrl.sv
// Directed bench for effect_param_ctrl: table of key/select vectors with hand-computed
// values and strobe counts, plus hand sequences for exact latencies and reset mid-hold.
module tb_effect_param_ctrl;

    logic        CLK;
    logic        RST_N;
    logic        key_up_n;
    logic        key_down_n;
    logic [1:0]  sel;
    logic        enable_sw;
    logic        disabled;
    logic [15:0] values;
    logic        upd_valid;
    logic [0:0]  upd_idx;

    effect_param_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY(20),
        .REPEAT_PERIOD(8)
    ) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .key_up_n(key_up_n),
        .key_down_n(key_down_n),
        .sel(sel),
        .enable_sw(enable_sw),
        .disabled(disabled),
        .values(values),
        .upd_valid(upd_valid),
        .upd_idx(upd_idx)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic       up_n;
        logic       dn_n;
        logic [1:0] sel;
        int         cycles;
        int         v0;
        int         v1;
        int         pulses;
        int         idx;
    } vec_t;

    vec_t vecs[$];
    int   n_vec;
    int   n_fail;
    int   pulses;
    int   last_idx;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Advance n rising edges, sampling 1 time unit after each edge.
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            #1;
            if (upd_valid) begin
                pulses++;
                last_idx = int'(upd_idx);
            end
        end
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        run(2);
        RST_N = 1'b1;
    endtask

    task automatic add(input logic up_n, input logic dn_n, input logic [1:0] s, input int cyc,
                       input int v0, input int v1, input int p, input int idx);
        vec_t v;
        v.up_n = up_n; v.dn_n = dn_n; v.sel = s; v.cycles = cyc;
        v.v0 = v0; v.v1 = v1; v.pulses = p; v.idx = idx;
        vecs.push_back(v);
    endtask

    initial begin
        n_vec = 0;
        n_fail = 0;
        pulses = 0;
        last_idx = 0;

        // Table starts from reset state {v1=1, v0=64}.
        // Down held on param 0: 15 steps of 4 reach the floor of 4, later steps are silent.
        add(1'b1, 1'b0, 2'b01, 160, 4, 1, 15, 0);
        add(1'b1, 1'b1, 2'b01, 10, 4, 1, 0, 0);
        for (int k = 1; k <= 7; k++) begin
            add(1'b0, 1'b1, 2'b10, 10, 4, (k < 5) ? k + 1 : 6, (k <= 5) ? 1 : 0, 1);
            add(1'b1, 1'b1, 2'b10, 10, 4, (k < 5) ? k + 1 : 6, 0, 0);
        end
        add(1'b0, 1'b0, 2'b01, 50, 4, 6, 0, 0);
        add(1'b1, 1'b1, 2'b01, 10, 4, 6, 0, 0);
        add(1'b0, 1'b1, 2'b00, 15, 4, 6, 0, 0);
        add(1'b1, 1'b1, 2'b00, 10, 4, 6, 0, 0);
        add(1'b0, 1'b1, 2'b01, 10, 8, 6, 1, 0);
        add(1'b1, 1'b1, 2'b01, 10, 8, 6, 0, 0);

        RST_N = 1'b0;
        key_up_n = 1'b1;
        key_down_n = 1'b1;
        sel = 2'b00;
        enable_sw = 1'b0;
        run(3);
        check("rst_values", int'(values), 16'h0140);
        check("rst_disabled", int'(disabled), 1);
        check("rst_upd_valid", int'(upd_valid), 0);
        check("rst_upd_idx", int'(upd_idx), 0);
        RST_N = 1'b1;
        run(2);

        // Enable switch reaches disabled on the third edge.
        enable_sw = 1'b1;
        run(2);
        check("en_edge2", int'(disabled), 1);
        run(1);
        check("en_edge3", int'(disabled), 0);

        // Single press: value changes on edge 7 with a one-cycle strobe.
        sel = 2'b01;
        pulses = 0;
        key_up_n = 1'b0;
        run(6);
        check("press_edge6_v0", int'(values[7:0]), 64);
        check("press_edge6_pulses", pulses, 0);
        run(1);
        check("press_edge7_v0", int'(values[7:0]), 68);
        check("press_edge7_valid", int'(upd_valid), 1);
        check("press_edge7_idx", int'(upd_idx), 0);
        run(1);
        check("press_edge8_valid", int'(upd_valid), 0);
        run(2);
        key_up_n = 1'b1;
        run(8);
        check("release_pulses", pulses, 1);

        // Glitch shorter than the debounce window.
        pulses = 0;
        key_up_n = 1'b0;
        run(3);
        key_up_n = 1'b1;
        run(10);
        check("glitch_v0", int'(values[7:0]), 68);
        check("glitch_pulses", pulses, 0);

        do_reset();
        run(4);
        for (int i = 0; i < vecs.size(); i++) begin
            key_up_n = vecs[i].up_n;
            key_down_n = vecs[i].dn_n;
            sel = vecs[i].sel;
            pulses = 0;
            run(vecs[i].cycles);
            check($sformatf("vec%0d_v0", i), int'(values[7:0]), vecs[i].v0);
            check($sformatf("vec%0d_v1", i), int'(values[15:8]), vecs[i].v1);
            check($sformatf("vec%0d_pulses", i), pulses, vecs[i].pulses);
            if (vecs[i].pulses != 0) begin
                check($sformatf("vec%0d_idx", i), last_idx, vecs[i].idx);
            end
        end

        // Auto-repeat up to 100, then reset while the key is still held.
        do_reset();
        run(4);
        sel = 2'b01;
        pulses = 0;
        key_up_n = 1'b0;
        run(83);
        check("repeat_v0_100", int'(values[7:0]), 100);
        check("repeat_pulses", pulses, 9);
        run(3);
        RST_N = 1'b0;
        #1;
        check("midreset_v0", int'(values[7:0]), 64);
        check("midreset_valid", int'(upd_valid), 0);
        check("midreset_disabled", int'(disabled), 1);
        run(2);
        RST_N = 1'b1;
        pulses = 0;
        run(6);
        check("repress_edge6_v0", int'(values[7:0]), 64);
        run(1);
        check("repress_edge7_v0", int'(values[7:0]), 68);
        check("repress_edge7_valid", int'(upd_valid), 1);
        key_up_n = 1'b1;
        run(10);
        check("repress_pulses", pulses, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
